// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared definitions for the vector memory sequencer:
//   - default parameter values for element width, vector length, address width
//   - op encoding sampled with start (load / store)
//   - FSM state enumeration used by vmem_seq
// -----------------------------------------------------------------------------
package vmem_pkg;

  localparam int DEF_ELEM_W   = 16;
  localparam int DEF_NUM_ELEM = 16;
  localparam int DEF_ADDR_W   = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vmem_addr_gen.sv
// -----------------------------------------------------------------------------
// vmem_addr_gen
// Element address accumulator with sticky overflow detection.
//   Clk1     in   clock, rising edge
//   Reset    in   synchronous active-high reset (clears wrap)
//   load     in   start of an operation: acc <= base, wrap cleared
//   advance  in   step to the next element: acc <= acc + step
//   base     in   first element address
//   step     in   element address increment
//   addr     out  address of the current element
//   wrap     out  sticky: some element address overflowed ADDR_W
// -----------------------------------------------------------------------------
module vmem_addr_gen
  import vmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  logic [ADDR_W-1:0] acc;
  logic [ADDR_W:0]   sum;

  // One bit wider than the address so the carry out is the overflow flag.
  assign sum  = {1'b0, acc} + {1'b0, step};
  assign addr = acc;

  always_ff @(posedge Clk1) begin
    if (load) begin
      acc <= base;
    end else if (advance) begin
      acc <= sum[ADDR_W-1:0];
    end
  end

  // Only advances toward an element that is actually issued are counted, so
  // the increment past the last element never raises a false overflow.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      wrap <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
    end else if (advance && sum[ADDR_W]) begin
      wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/vmem_seq.sv
// -----------------------------------------------------------------------------
// vmem_seq
// Vector load/store sequencer: turns one start request into NUM_ELEM
// single-element memory accesses at base + k*step.
//
// Optional feature macro: VMEM_SEQ_STRIDE_EN
//   defined   : stride port present, step = stride (0 repeats base)
//   undefined : no stride port, step = 1
//
// Ports
//   Clk1     in   sole clock, rising edge
//   Reset    in   synchronous active-high reset
//   start    in   one-cycle request, honoured only when idle
//   op       in   0 = load, 1 = store (sampled with start)
//   base     in   first element address (sampled with start)
//   stride   in   element increment (VMEM_SEQ_STRIDE_EN builds only)
//   vec_in   in   store source, element k at [k*ELEM_W +: ELEM_W]
//   vec_out  out  load result, same packing; holds until the next load
//   Addr     out  registered memory address
//   RD, WR   out  registered read / write strobes, mutually exclusive
//   DataOut  out  store data, valid while WR is high
//   DataIn   in   read data, valid in the cycle after the RD cycle
//   busy     out  high whenever the FSM is not idle
//   done     out  one-cycle completion pulse
//   wrap     out  sticky: an element address overflowed ADDR_W
//
// Timing (start sampled on edge 0): strobes are high on cycles 1..NUM_ELEM;
// done rises NUM_ELEM+2 edges after start for a load, NUM_ELEM+1 for a store.
// -----------------------------------------------------------------------------
module vmem_seq
  import vmem_pkg::*;
#(
  parameter int ELEM_W   = DEF_ELEM_W,
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       Clk1,
  input  logic                       Reset,
  input  logic                       start,
  input  logic                       op,
  input  logic [ADDR_W-1:0]          base,
`ifdef VMEM_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0]          stride,
`endif
  input  logic [NUM_ELEM*ELEM_W-1:0] vec_in,
  output logic [NUM_ELEM*ELEM_W-1:0] vec_out,
  output logic [ADDR_W-1:0]          Addr,
  output logic                       RD,
  output logic                       WR,
  output logic [ELEM_W-1:0]          DataOut,
  input  logic [ELEM_W-1:0]          DataIn,
  output logic                       busy,
  output logic                       done,
  output logic                       wrap
);

  localparam int IDX_W = $clog2(NUM_ELEM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              issue;
  logic              last;
  logic              advance;

  logic [CNT_W-1:0]  cnt;
  logic              op_r;
  logic [ELEM_W-1:0] vec_r [NUM_ELEM];
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] addr_cur;

  logic [IDX_W-1:0]  elem_p1;
  logic [IDX_W-1:0]  elem_p2;
  logic              rd_p2;
  logic [ELEM_W-1:0] vout [NUM_ELEM];

  // FSM state register
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and per-cycle control decisions
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        last  = (cnt == LAST);
        if (last) begin
          // A load still has the final read beat in flight.
          state_nxt = (op_r == OP_STORE) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign advance = issue && !last;

  // Operand capture at start
  always_ff @(posedge Clk1) begin
    if (accept) begin
      op_r <= op;
      for (int i = 0; i < NUM_ELEM; i++) begin
        vec_r[i] <= vec_in[i*ELEM_W +: ELEM_W];
      end
    end
  end

`ifdef VMEM_SEQ_STRIDE_EN
  logic [ADDR_W-1:0] step_r;

  always_ff @(posedge Clk1) begin
    if (accept) begin
      step_r <= stride;
    end
  end

  assign step = step_r;
`else
  assign step = ADDR_W'(1);
`endif

  // Element counter: one extra bit so reaching NUM_ELEM never wraps to zero.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= cnt + 1'b1;
    end
  end

  vmem_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .load    (accept),
    .advance (advance),
    .base    (base),
    .step    (step),
    .addr    (addr_cur),
    .wrap    (wrap)
  );

  // Stage p1: registered memory request (strobes, address, store data)
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      RD   <= 1'b0;
      WR   <= 1'b0;
      done <= 1'b0;
    end else begin
      RD   <= issue && (op_r == OP_LOAD);
      WR   <= issue && (op_r == OP_STORE);
      done <= (state == S_DONE);
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      Addr    <= '0;
      DataOut <= '0;
    end else if (issue) begin
      Addr    <= addr_cur;
      DataOut <= vec_r[cnt[IDX_W-1:0]];
    end
  end

  always_ff @(posedge Clk1) begin
    if (issue) begin
      elem_p1 <= cnt[IDX_W-1:0];
    end
  end

  // Stage p2: read data returns; element index travels with the RD beat
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      rd_p2 <= 1'b0;
    end else begin
      rd_p2 <= RD;
    end
  end

  always_ff @(posedge Clk1) begin
    elem_p2 <= elem_p1;
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        vout[i] <= '0;
      end
    end else if (rd_p2) begin
      vout[elem_p2] <= DataIn;
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_pack
    assign vec_out[g*ELEM_W +: ELEM_W] = vout[g];
  end

endmodule

// File: tb/tb_vmem_seq.sv
// -----------------------------------------------------------------------------
// tb_vmem_seq
// Self-checking bench for vmem_seq (default parameters). Expected addresses,
// strobe windows, latencies, overflow and load results are derived from the
// sequencer's behavioural rules with plain arithmetic; a simple memory
// responder returns mem(a) = a ^ salt one cycle after each RD cycle and junk
// otherwise.
// -----------------------------------------------------------------------------
module tb_vmem_seq;

  localparam int N  = 16;
  localparam int EW = 16;
  localparam int AW = 16;
  localparam logic [EW-1:0] JUNK = 16'hDEAD;

  logic            Clk1;
  logic            Reset;
  logic            start;
  logic            op;
  logic [AW-1:0]   base;
`ifdef VMEM_SEQ_STRIDE_EN
  logic [AW-1:0]   stride;
  logic [AW-1:0]   cur_stride;
`endif
  logic [N*EW-1:0] vec_in;
  logic [N*EW-1:0] vec_out;
  logic [AW-1:0]   Addr;
  logic            RD;
  logic            WR;
  logic [EW-1:0]   DataOut;
  logic [EW-1:0]   DataIn;
  logic            busy;
  logic            done;
  logic            wrap;

  int              checks;
  int              errors;
  logic [EW-1:0]   salt;
  logic            prev_rd;
  logic [AW-1:0]   prev_addr;
  logic [N*EW-1:0] exp_vout;

  vmem_seq dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .start   (start),
    .op      (op),
    .base    (base),
`ifdef VMEM_SEQ_STRIDE_EN
    .stride  (stride),
`endif
    .vec_in  (vec_in),
    .vec_out (vec_out),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .DataIn  (DataIn),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  initial begin
    Clk1 = 1'b0;
    forever #5 Clk1 = ~Clk1;
  end

  function automatic logic [EW-1:0] mem_val(input logic [AW-1:0] a);
    return a ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [N*EW-1:0] obs, input logic [N*EW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock, sample #1 after the edge, and play the memory side.
  task automatic cycle();
    @(posedge Clk1);
    #1;
    DataIn    = prev_rd ? mem_val(prev_addr) : JUNK;
    prev_rd   = RD;
    prev_addr = Addr;
  endtask

  task automatic run_op(input logic op_i, input logic [AW-1:0] base_i,
                        input logic [N*EW-1:0] vec_i, input bit dbl_start);
    logic [AW-1:0]   ea [N];
    logic [AW-1:0]   step;
    logic            ewrap;
    logic [N*EW-1:0] new_vout;
    logic            wrap_done;
    int rd_n, wr_n, s, first_s, last_s, addr_bad, data_bad, both, done_at, done_n, busy_bad, exp_done;
`ifdef VMEM_SEQ_STRIDE_EN
    step = cur_stride;
`else
    step = 16'd1;
`endif
    for (int k = 0; k < N; k++) begin
      ea[k] = AW'(int'(base_i) + k * int'(step));
      new_vout[k*EW +: EW] = mem_val(ea[k]);
    end
    ewrap    = (int'(base_i) + (N - 1) * int'(step)) > 65535;
    exp_done = (op_i == 1'b1) ? N + 1 : N + 2;

    op     = op_i;
    base   = base_i;
    vec_in = vec_i;
`ifdef VMEM_SEQ_STRIDE_EN
    stride = cur_stride;
`endif
    start  = 1'b1;
    cycle();
    start  = 1'b0;
    op     = 1'($urandom);
    base   = 16'($urandom);
    vec_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef VMEM_SEQ_STRIDE_EN
    stride = 16'($urandom);
`endif
    chk("busy_after_start", busy, 1'b1);
    chk("wrap_cleared_at_start", wrap, 1'b0);
    chk("vec_out_held", vec_out, exp_vout);

    rd_n = 0; wr_n = 0; s = 0; first_s = -1; last_s = -1; addr_bad = 0; data_bad = 0;
    both = 0; done_at = -1; done_n = 0; busy_bad = 0; wrap_done = 1'bx;
    for (int j = 1; j <= 40; j++) begin
      if (dbl_start && j == 5) begin
        start = 1'b1;
        op    = ~op_i;
        base  = base_i + 16'h0400;
      end
      cycle();
      start = 1'b0;
      if (RD && WR) both++;
      if (RD || WR) begin
        if (first_s < 0) first_s = j;
        last_s = j;
        if (s < N) begin
          if (Addr !== ea[s]) addr_bad++;
          if (WR && (DataOut !== vec_i[s*EW +: EW])) data_bad++;
        end
        s++;
      end
      if (RD) rd_n++;
      if (WR) wr_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at   = j;
          wrap_done = wrap;
        end
      end
      if (done_at < 0 && !busy) busy_bad++;
      if (done_at >= 0 && j >= done_at + 2) break;
    end

    chk("done_latency", done_at, exp_done);
    chk("done_pulse_count", done_n, 1);
    chk("first_strobe_cycle", first_s, 1);
    chk("last_strobe_cycle", last_s, N);
    chk("rd_count", rd_n, (op_i == 1'b1) ? 0 : N);
    chk("wr_count", wr_n, (op_i == 1'b1) ? N : 0);
    chk("addr_errors", addr_bad, 0);
    chk("store_data_errors", data_bad, 0);
    chk("rd_wr_overlap", both, 0);
    chk("busy_drop_early", busy_bad, 0);
    chk("wrap_at_done", wrap_done, ewrap);
    chk("busy_after_done", busy, 1'b0);
    if (op_i == 1'b0) exp_vout = new_vout;
    chk("vec_out_final", vec_out, exp_vout);
  endtask

  initial begin
    logic [N*EW-1:0] v;
    int wr_seen, rd_seen, done_seen;
    checks = 0; errors = 0; salt = '0;
    prev_rd = 1'b0; prev_addr = '0;
    Reset = 1'b1; start = 1'b0; op = 1'b0; base = '0; vec_in = '0; DataIn = JUNK;
`ifdef VMEM_SEQ_STRIDE_EN
    stride = '0; cur_stride = 16'd1;
`endif
    cycle();
    cycle();
    chk("reset_rd", RD, 1'b0);
    chk("reset_wr", WR, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_addr", Addr, 16'h0000);
    chk("reset_dataout", DataOut, 16'h0000);
    chk("reset_vec_out", vec_out, '0);
    exp_vout = '0;
    Reset = 1'b0;
    cycle();

    // Load from identity memory at 0x0100.
    run_op(1'b0, 16'h0100, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Store k*3 at 0x0200; vec_out must keep the previous load result.
    for (int k = 0; k < N; k++) v[k*EW +: EW] = EW'(k * 3);
    run_op(1'b1, 16'h0200, v, 1'b0);

`ifdef VMEM_SEQ_STRIDE_EN
    cur_stride = 16'h0004;
    run_op(1'b0, 16'h0000, v, 1'b0);
    cur_stride = 16'h0000;
    run_op(1'b0, 16'h1234, v, 1'b0);
    cur_stride = 16'd1;
`endif

    // Address overflow, then a clean load must clear wrap.
    salt = 16'h5A5A;
    run_op(1'b0, 16'hFFFE, v, 1'b0);
    run_op(1'b0, 16'h0100, v, 1'b0);

    // Second start mid-load is ignored.
    salt = 16'h0F0F;
    run_op(1'b0, 16'h3000, v, 1'b1);

    // Reset during a store at cycle 8.
    op = 1'b1; base = 16'h0200; vec_in = v; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 1; j <= 7; j++) cycle();
    chk("store_active_before_reset", WR, 1'b1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    exp_vout = '0;
    chk("reset_mid_wr", WR, 1'b0);
    chk("reset_mid_busy", busy, 1'b0);
    chk("reset_mid_addr", Addr, 16'h0000);
    chk("reset_mid_vec_out", vec_out, exp_vout);
    wr_seen = 0; rd_seen = 0; done_seen = 0;
    for (int j = 0; j < 25; j++) begin
      cycle();
      if (WR) wr_seen++;
      if (RD) rd_seen++;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_wr", wr_seen, 0);
    chk("abort_no_rd", rd_seen, 0);
    run_op(1'b0, 16'h0040, v, 1'b0);

    // Randomized mix of loads and stores.
    for (int r = 0; r < 6; r++) begin
      salt = 16'($urandom);
`ifdef VMEM_SEQ_STRIDE_EN
      cur_stride = 16'($urandom_range(0, 8));
`endif
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_op(1'($urandom), (r == 3) ? 16'hFFF8 : 16'($urandom), v, (r == 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
